// File: rtl/cellram_pkg.sv
`timescale 1ns/1ps
// Shared state encoding, register-select codes and reset constants for the
// CellularRAM responder.
package cellram_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_DRIVE,
    ST_WR,
    ST_CFG_WR
  } state_t;

  localparam logic [1:0]  SEL_RCR = 2'b00;
  localparam logic [1:0]  SEL_BCR = 2'b10;
  localparam logic [15:0] BCR_RST = 16'h9D1F;
  localparam logic [15:0] RCR_RST = 16'h0010;
  localparam logic [15:0] TRI_Z   = 16'hZZZZ;

endpackage

// File: rtl/cellram_array.sv
`timescale 1ns/1ps
// Word array for the responder: simple dual-port RAM with per-byte write
// enables and a registered read port so it maps onto block RAM.
module cellram_array
  import cellram_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic [1:0]           wr_be,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [15:0]          wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [15:0]          rd_data
);

  logic [15:0] mem [2**ADDR_BITS];

  // wr_be[1] is the upper lane, wr_be[0] the lower lane
  always_ff @(posedge clk) begin
    if (wr_be[1]) mem[wr_addr][15:8] <= wr_data[15:8];
    if (wr_be[0]) mem[wr_addr][7:0]  <= wr_data[7:0];
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/cellram_responder.sv
`timescale 1ns/1ps
// Asynchronous-mode CellularRAM device model with BCR/RCR emulation and
// protocol checking. CELLRAM_PWRUP_CHECK_EN enables the power-up interval.
//
// state       | meaning
// ST_PWRUP    | power-up wait; any CE access is flagged
// ST_IDLE     | waiting for a read or write cycle
// ST_RD_WAIT  | read latency countdown
// ST_RD_DRIVE | read data presented on the bus
// ST_WR       | array write, measuring WE low time
// ST_CFG_WR   | configuration-register write, measuring WE low time
module cellram_responder
  import cellram_pkg::*;
#(
  parameter int ADDR_BITS    = 8,
  parameter int RD_LAT       = 7,
  parameter int WR_MIN       = 6,
  parameter int PWRUP_CYCLES = 15000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [22:0] addr_mem,
  inout  wire  [15:0] data_mem,
  input  logic        CE,
  input  logic        WE,
  input  logic        OE,
  input  logic        UB,
  input  logic        LB,
  input  logic        ADV,
  input  logic        CRE,
  output logic        ready,
  output logic        err,
  output logic [15:0] bcr,
  output logic [15:0] rcr
);

  localparam int RC_W = $clog2(RD_LAT + 1);
  localparam int WC_W = $clog2(WR_MIN + 1);

  state_t           state;
  logic [22:0]      s_addr, rd_addr, w_addr;
  logic [15:0]      s_data, w_data, ram_rdata, rd_word, dout_q;
  logic             s_ce, s_we, s_oe, s_ub, s_lb, s_cre;
  logic             w_ub, w_lb;
  logic [RC_W-1:0]  rd_cnt;
  logic [WC_W-1:0]  wr_cnt;
  logic             wr_ok, wr_end;
  logic [1:0]       ram_be;
  logic             drive_hi, drive_lo;
  logic             unused_pins;

`ifdef CELLRAM_PWRUP_CHECK_EN
  localparam int PW_W = $clog2(PWRUP_CYCLES + 1);
  logic [PW_W-1:0] pw_cnt;
`else
  logic unused_pwrup;
  assign unused_pwrup = (PWRUP_CYCLES > 0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_addr <= '0;
      s_data <= '0;
      s_ce   <= 1'b1;
      s_we   <= 1'b1;
      s_oe   <= 1'b1;
      s_ub   <= 1'b1;
      s_lb   <= 1'b1;
      s_cre  <= 1'b0;
    end else begin
      s_addr <= addr_mem;
      s_data <= data_mem;
      s_ce   <= CE;
      s_we   <= WE;
      s_oe   <= OE;
      s_ub   <= UB;
      s_lb   <= LB;
      s_cre  <= CRE;
    end
  end

  assign wr_ok  = (wr_cnt >= WC_W'(WR_MIN));
  assign wr_end = s_we | s_ce;
  assign ram_be = (state == ST_WR && wr_end && wr_ok) ? ~{w_ub, w_lb} : 2'b00;

  always_comb begin
    rd_word = ram_rdata;
    if (s_cre) begin
      if (s_addr[19:18] == SEL_BCR)      rd_word = bcr;
      else if (s_addr[19:18] == SEL_RCR) rd_word = rcr;
      else                               rd_word = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
`ifdef CELLRAM_PWRUP_CHECK_EN
      state  <= ST_PWRUP;
      pw_cnt <= PW_W'(PWRUP_CYCLES);
`else
      state  <= ST_IDLE;
`endif
      ready   <= 1'b0;
      err     <= 1'b0;
      bcr     <= BCR_RST;
      rcr     <= RCR_RST;
      rd_cnt  <= '0;
      rd_addr <= '0;
      wr_cnt  <= '0;
      w_addr  <= '0;
      w_data  <= '0;
      w_ub    <= 1'b1;
      w_lb    <= 1'b1;
      dout_q  <= '0;
    end else begin
`ifndef CELLRAM_PWRUP_CHECK_EN
      ready <= 1'b1;
`endif
      case (state)
        ST_PWRUP: begin
`ifdef CELLRAM_PWRUP_CHECK_EN
          if (!s_ce) err <= 1'b1;
          if (pw_cnt == '0) begin
            state <= ST_IDLE;
            ready <= 1'b1;
          end else begin
            pw_cnt <= pw_cnt - 1'b1;
          end
`else
          state <= ST_IDLE;
`endif
        end

        ST_IDLE: begin
          if (!s_ce && !s_we) begin
            state  <= s_cre ? ST_CFG_WR : ST_WR;
            wr_cnt <= WC_W'(1);
            w_addr <= s_addr;
            w_data <= s_data;
            w_ub   <= s_ub;
            w_lb   <= s_lb;
          end else if (!s_ce && !s_oe) begin
            state   <= ST_RD_WAIT;
            rd_cnt  <= RC_W'(RD_LAT - 2);
            rd_addr <= s_addr;
          end
        end

        ST_RD_WAIT, ST_RD_DRIVE: begin
          dout_q <= rd_word;
          if (s_ce) begin
            state <= ST_IDLE;
          end else if (!s_we) begin
            // a write strobe inside a read cycle is a protocol error but still honoured
            state  <= ST_WR;
            err    <= 1'b1;
            wr_cnt <= WC_W'(1);
            w_addr <= s_addr;
            w_data <= s_data;
            w_ub   <= s_ub;
            w_lb   <= s_lb;
          end else if (s_oe) begin
            state <= ST_IDLE;
          end else if (s_addr != rd_addr) begin
            state   <= ST_RD_WAIT;
            rd_cnt  <= RC_W'(RD_LAT - 2);
            rd_addr <= s_addr;
          end else if (state == ST_RD_WAIT) begin
            if (rd_cnt == '0) state <= ST_RD_DRIVE;
            else              rd_cnt <= rd_cnt - 1'b1;
          end
        end

        ST_WR, ST_CFG_WR: begin
          if (wr_end) begin
            state <= ST_IDLE;
            if (!wr_ok) begin
              err <= 1'b1;
            end else if (state == ST_CFG_WR) begin
              if (w_addr[19:18] == SEL_BCR)      bcr <= w_addr[15:0];
              else if (w_addr[19:18] == SEL_RCR) rcr <= w_addr[15:0];
              else                               err <= 1'b1;
            end
          end else begin
            w_addr <= s_addr;
            w_data <= s_data;
            w_ub   <= s_ub;
            w_lb   <= s_lb;
            if (!wr_ok) wr_cnt <= wr_cnt + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  cellram_array #(.ADDR_BITS(ADDR_BITS)) u_array (
    .clk     (clk),
    .wr_be   (ram_be),
    .wr_addr (w_addr[ADDR_BITS-1:0]),
    .wr_data (w_data),
    .rd_addr (s_addr[ADDR_BITS-1:0]),
    .rd_data (ram_rdata)
  );

  // release follows the raw pins so the bus lets go in the same cycle
  assign drive_hi = (state == ST_RD_DRIVE) & ~OE & ~CE & ~UB;
  assign drive_lo = (state == ST_RD_DRIVE) & ~OE & ~CE & ~LB;
  assign data_mem[15:8] = drive_hi ? dout_q[15:8] : TRI_Z[15:8];
  assign data_mem[7:0]  = drive_lo ? dout_q[7:0]  : TRI_Z[7:0];

  assign unused_pins = ^{ADV, w_addr};

endmodule

// File: tb/tb_cellram_responder.sv
`timescale 1ns/1ps
// Self-checking bench for cellram_responder. The bus has a pull-up so a
// released lane reads back as 8'hFF.
module tb_cellram_responder;

  localparam int ADDR_BITS = 8;
  localparam int RD_LAT    = 7;
  localparam int WR_MIN    = 6;
  localparam int PW        = 15000;
`ifdef CELLRAM_PWRUP_CHECK_EN
  localparam int EXP_RDY = PW + 1;
`else
  localparam int EXP_RDY = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [22:0] addr_mem;
  tri1  [15:0] data_mem;
  logic        CE, WE, OE, UB, LB, ADV, CRE;
  logic        ready, err;
  logic [15:0] bcr, rcr;
  logic        tb_drv;
  logic [15:0] tb_data;

  int n_tests = 0;
  int n_fail  = 0;

  assign data_mem = tb_drv ? tb_data : 16'hzzzz;

  always #5 clk = ~clk;

  cellram_responder #(
    .ADDR_BITS(ADDR_BITS), .RD_LAT(RD_LAT), .WR_MIN(WR_MIN), .PWRUP_CYCLES(PW)
  ) dut (
    .clk(clk), .reset(reset), .addr_mem(addr_mem), .data_mem(data_mem),
    .CE(CE), .WE(WE), .OE(OE), .UB(UB), .LB(LB), .ADV(ADV), .CRE(CRE),
    .ready(ready), .err(err), .bcr(bcr), .rcr(rcr)
  );

  task automatic idle_pins();
    CE = 1'b1; WE = 1'b1; OE = 1'b1; UB = 1'b1; LB = 1'b1;
    CRE = 1'b0; ADV = 1'b0; tb_drv = 1'b0;
  endtask

  task automatic do_write(input logic [22:0] a, input logic [15:0] d,
                          input logic ub, input logic lb, input logic cre, input int len);
    @(negedge clk);
    addr_mem = a; tb_data = d; tb_drv = 1'b1;
    UB = ub; LB = lb; CRE = cre; OE = 1'b1; CE = 1'b0; WE = 1'b0;
    repeat (len) @(posedge clk);
    @(negedge clk);
    idle_pins();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic start_read(input logic [22:0] a, input logic ub, input logic lb, input logic cre);
    @(negedge clk);
    addr_mem = a; UB = ub; LB = lb; CRE = cre; WE = 1'b1; CE = 1'b0; OE = 1'b0;
  endtask

  task automatic stop_read();
    @(negedge clk);
    idle_pins();
    #1;
  endtask

  task automatic do_reset(output int edges);
    @(negedge clk);
    reset = 1'b0;
    idle_pins();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    edges = 0;
    while (ready !== 1'b1 && edges < PW + 20) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    idle_pins();
    addr_mem = '0; tb_data = '0; reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (data_mem !== 16'hFFFF) begin n_fail++; $display("FAIL reset_bus: got %h want ffff", data_mem); end
    n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_tests++; if (bcr !== 16'h9D1F) begin n_fail++; $display("FAIL reset_bcr: got %h want 9d1f", bcr); end
    n_tests++; if (rcr !== 16'h0010) begin n_fail++; $display("FAIL reset_rcr: got %h want 0010", rcr); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge: got %b want 0", ready); end
`ifdef CELLRAM_PWRUP_CHECK_EN
    for (int k = 1; k <= PW + 1; k++) begin
      @(posedge clk); #1;
      if (k == 99)  CE = 1'b0;
      if (k == 100) CE = 1'b1;
      if (k == 103) begin
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL pwrup_access_err: got %b want 1", err); end
        n_tests++; if (data_mem !== 16'hFFFF) begin n_fail++; $display("FAIL pwrup_bus: got %h want ffff", data_mem); end
      end
      if (k == PW) begin
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL pwrup_ready_early: got %b want 0", ready); end
      end
      if (k == PW + 1) begin
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL pwrup_ready: got %b want 1", ready); end
      end
    end
`else
    @(posedge clk); #1;
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL ready_first_edge: got %b want 1", ready); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_after_reset: got %b want 0", err); end
`endif
  endtask

  task automatic test_write_read();
    do_write(23'h3055AA, 16'hEEFF, 1'b0, 1'b0, 1'b0, 8);
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b want 0", err); end
    start_read(23'h3055AA, 1'b0, 1'b0, 1'b0);
    repeat (RD_LAT) @(posedge clk);
    #1;
    n_tests++; if (data_mem !== 16'hFFFF) begin n_fail++; $display("FAIL rd_early: got %h want ffff", data_mem); end
    @(posedge clk); #1;
    n_tests++; if (data_mem !== 16'hEEFF) begin n_fail++; $display("FAIL rd_latency: got %h want eeff", data_mem); end
    stop_read();
    n_tests++; if (data_mem !== 16'hFFFF) begin n_fail++; $display("FAIL rd_release: got %h want ffff", data_mem); end
  endtask

  task automatic test_byte_lanes();
    do_write(23'h3055AA, 16'h1234, 1'b0, 1'b1, 1'b0, 8);
    start_read(23'h3055AA, 1'b0, 1'b0, 1'b0);
    repeat (RD_LAT + 1) @(posedge clk);
    #1;
    n_tests++; if (data_mem !== 16'h12FF) begin n_fail++; $display("FAIL lane_merge: got %h want 12ff", data_mem); end
    stop_read();
    start_read(23'h3055AA, 1'b1, 1'b0, 1'b0);
    repeat (RD_LAT + 1) @(posedge clk);
    #1;
    n_tests++; if (data_mem !== 16'hFFFF) begin n_fail++; $display("FAIL lane_ub_off: got %h want ffff", data_mem); end
    stop_read();
    start_read(23'h3055AA, 1'b0, 1'b1, 1'b0);
    repeat (RD_LAT + 1) @(posedge clk);
    #1;
    n_tests++; if (data_mem !== 16'h12FF) begin n_fail++; $display("FAIL lane_lb_off: got %h want 12ff", data_mem); end
    stop_read();
  endtask

  task automatic test_alias_restart();
    do_write(23'h000105, 16'hA5C3, 1'b0, 1'b0, 1'b0, 7);
    do_write(23'h000077, 16'h3C5A, 1'b0, 1'b0, 1'b0, 6);
    start_read(23'h000005, 1'b0, 1'b0, 1'b0);
    repeat (RD_LAT + 1) @(posedge clk);
    #1;
    n_tests++; if (data_mem !== 16'hA5C3) begin n_fail++; $display("FAIL alias: got %h want a5c3", data_mem); end
    stop_read();
    start_read(23'h000005, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    addr_mem = 23'h000077;
    for (int k = 1; k <= RD_LAT + 1; k++) begin
      @(posedge clk); #1;
      if (k <= RD_LAT) begin
        n_tests++; if (data_mem !== 16'hFFFF) begin n_fail++; $display("FAIL restart_early k=%0d: got %h want ffff", k, data_mem); end
      end else begin
        n_tests++; if (data_mem !== 16'h3C5A) begin n_fail++; $display("FAIL restart_data: got %h want 3c5a", data_mem); end
      end
    end
    stop_read();
  endtask

  task automatic test_short_write();
    do_write(23'h3055AA, 16'h5555, 1'b0, 1'b0, 1'b0, 3);
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL short_err: got %b want 1", err); end
    start_read(23'h3055AA, 1'b0, 1'b0, 1'b0);
    repeat (RD_LAT + 1) @(posedge clk);
    #1;
    n_tests++; if (data_mem !== 16'h12FF) begin n_fail++; $display("FAIL short_unchanged: got %h want 12ff", data_mem); end
    stop_read();
  endtask

  task automatic test_reset_mid();
    int edges;
    start_read(23'h3055AA, 1'b0, 1'b0, 1'b0);
    repeat (RD_LAT + 1) @(posedge clk);
    #1;
    n_tests++; if (data_mem !== 16'h12FF) begin n_fail++; $display("FAIL mid_drive: got %h want 12ff", data_mem); end
    #2 reset = 1'b0;
    #1;
    n_tests++; if (data_mem !== 16'hFFFF) begin n_fail++; $display("FAIL mid_release: got %h want ffff", data_mem); end
    n_tests++; if (err !== 1'b0 || ready !== 1'b0) begin n_fail++; $display("FAIL mid_flags: got err=%b ready=%b want 0 0", err, ready); end
    do_reset(edges);
    n_tests++; if (edges != EXP_RDY) begin n_fail++; $display("FAIL mid_ready_edges: got %0d want %0d", edges, EXP_RDY); end
  endtask

  task automatic test_config();
    n_tests++; if (bcr !== 16'h9D1F) begin n_fail++; $display("FAIL cfg_bcr_rst: got %h want 9d1f", bcr); end
    do_write(23'h080010, 16'hBEEF, 1'b0, 1'b0, 1'b1, 8);
    n_tests++; if (bcr !== 16'h0010) begin n_fail++; $display("FAIL cfg_bcr: got %h want 0010", bcr); end
    n_tests++; if (rcr !== 16'h0010) begin n_fail++; $display("FAIL cfg_rcr_keep: got %h want 0010", rcr); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL cfg_err0: got %b want 0", err); end
    start_read(23'h080010, 1'b0, 1'b0, 1'b1);
    repeat (RD_LAT + 1) @(posedge clk);
    #1;
    n_tests++; if (data_mem !== 16'h0010) begin n_fail++; $display("FAIL cfg_rd_bcr: got %h want 0010", data_mem); end
    stop_read();
    do_write(23'h00ABCD, 16'h0000, 1'b0, 1'b0, 1'b1, 6);
    n_tests++; if (rcr !== 16'hABCD || bcr !== 16'h0010) begin n_fail++; $display("FAIL cfg_rcr: got rcr=%h bcr=%h want abcd 0010", rcr, bcr); end
    start_read(23'h00ABCD, 1'b0, 1'b0, 1'b1);
    repeat (RD_LAT + 1) @(posedge clk);
    #1;
    n_tests++; if (data_mem !== 16'hABCD) begin n_fail++; $display("FAIL cfg_rd_rcr: got %h want abcd", data_mem); end
    stop_read();
    do_write(23'h041111, 16'h0000, 1'b0, 1'b0, 1'b1, 8);
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL cfg_bad_sel_err: got %b want 1", err); end
    n_tests++; if (rcr !== 16'hABCD || bcr !== 16'h0010) begin n_fail++; $display("FAIL cfg_bad_sel_keep: got rcr=%h bcr=%h", rcr, bcr); end
  endtask

  task automatic test_random();
    logic [15:0] model [256];
    int          idx [8];
    int          edges, k, len;
    logic [15:0] d, expv;
    logic [22:0] a;
    logic        ub, lb, m_err;
    do_reset(edges);
    n_tests++; if (edges != EXP_RDY) begin n_fail++; $display("FAIL rnd_ready_edges: got %0d want %0d", edges, EXP_RDY); end
    for (int i = 0; i < 8; i++) begin
      idx[i] = i * 29 + int'($urandom_range(0, 28));
      d = 16'($urandom());
      a = {15'($urandom()), idx[i][7:0]};
      do_write(a, d, 1'b0, 1'b0, 1'b0, WR_MIN + int'($urandom_range(0, 3)));
      model[idx[i]] = d;
    end
    m_err = 1'b0;
    for (int t = 0; t < 40; t++) begin
      k  = idx[$urandom_range(0, 7)];
      a  = {15'($urandom()), k[7:0]};
      ub = 1'($urandom());
      lb = 1'($urandom());
      if ($urandom_range(0, 1) == 1) begin
        d = 16'($urandom());
        len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, WR_MIN - 1))
                                          : int'($urandom_range(WR_MIN, WR_MIN + 4));
        if (len >= WR_MIN) begin
          if (!ub) model[k][15:8] = d[15:8];
          if (!lb) model[k][7:0]  = d[7:0];
        end else begin
          m_err = 1'b1;
        end
        do_write(a, d, ub, lb, 1'b0, len);
        n_tests++; if (err !== m_err) begin n_fail++; $display("FAIL rnd_err t=%0d len=%0d: got %b want %b", t, len, err, m_err); end
      end else begin
        start_read(a, ub, lb, 1'b0);
        repeat (RD_LAT + 1) @(posedge clk);
        #1;
        expv = {ub ? 8'hFF : model[k][15:8], lb ? 8'hFF : model[k][7:0]};
        n_tests++; if (data_mem !== expv) begin n_fail++; $display("FAIL rnd_read t=%0d addr=%h: got %h want %h", t, a, data_mem, expv); end
        stop_read();
        n_tests++; if (data_mem !== 16'hFFFF) begin n_fail++; $display("FAIL rnd_release t=%0d: got %h want ffff", t, data_mem); end
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_alias_restart();
    test_short_write();
    test_reset_mid();
    test_config();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
